// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush / multi-cycle MDU stall controller beside the ID/EX register.
// Optional performance counters are enabled with `define HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int unsigned REGADDR_WIDTH = 4,
  parameter int unsigned MDU_TIMEOUT   = 64,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REGADDR_WIDTH-1:0] id_rs,
  input  logic [REGADDR_WIDTH-1:0] id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic                     id_ex_mem_read,
  input  logic [REGADDR_WIDTH-1:0] id_ex_rd,
  input  logic                     ex_branch_taken,
  input  logic                     ex_mdu_start,
  input  logic                     mdu_done,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     if_id_flush,
  output logic                     id_ex_write,
  output logic                     id_ex_bubble,
  output logic                     ex_mem_bubble,
  output logic                     mdu_timeout
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     stall_cycles,
  output logic [CNT_WIDTH-1:0]     flush_count
`endif
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MDU_WAIT = 1'b1;

  localparam int unsigned CW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MDU_TIMEOUT - 1);

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          load_use;
  logic          timeout_hit;

  assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_uses_rs && (id_ex_rd == id_rs)) ||
                     (id_uses_rt && (id_ex_rd == id_rt)));

  // Outputs are forced to pass-through while reset is held, whatever the inputs do.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (rst_n) begin
      if (state == MDU_WAIT) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      RUN: begin
        if (!ex_branch_taken && ex_mdu_start)
          state_nxt = MDU_WAIT;
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = RUN;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RUN)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 1'b1;
      if (timeout_hit)
        mdu_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write)
        stall_cycles <= stall_cycles + 1'b1;
      if (if_id_flush)
        flush_count <= flush_count + 1'b1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed + randomized bench for hazard_stall_ctrl against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int unsigned RW  = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned CNW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs, id_rt, id_ex_rd;
  logic          id_uses_rs, id_uses_rt, id_ex_mem_read;
  logic          ex_branch_taken, ex_mdu_start, mdu_done;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write;
  logic          id_ex_bubble, ex_mem_bubble, mdu_timeout;
`ifdef HAZARD_STALL_CNT_EN
  logic [CNW-1:0] stall_cycles, flush_count;
`endif

  hazard_stall_ctrl #(.REGADDR_WIDTH(RW), .MDU_TIMEOUT(TMO), .CNT_WIDTH(CNW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mdu_timeout(mdu_timeout)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model: "waiting" plus number of wait cycles already spent.
  bit          m_waiting;
  int unsigned m_spent;
  bit          m_sticky;
  longint unsigned m_stalls, m_flushes;
  bit e_pc, e_ifw, e_flush, e_idw, e_bub, e_exb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard();
    return id_ex_mem_read && id_ex_rd != 0 &&
           ((id_uses_rs && id_ex_rd == id_rs) || (id_uses_rt && id_ex_rd == id_rt));
  endfunction

  task automatic expect_outputs();
    {e_pc, e_ifw, e_flush, e_idw, e_bub, e_exb} = 6'b110100;
    if (rst_n) begin
      if (m_waiting)            {e_pc, e_ifw, e_flush, e_idw, e_bub, e_exb} = 6'b000001;
      else if (ex_branch_taken) {e_pc, e_ifw, e_flush, e_idw, e_bub, e_exb} = 6'b111110;
      else if (hazard())        {e_pc, e_ifw, e_flush, e_idw, e_bub, e_exb} = 6'b000110;
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_spent = 0; m_sticky = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    expect_outputs();
    chk({tag, ".pc_write"},      pc_write,      e_pc);
    chk({tag, ".if_id_write"},   if_id_write,   e_ifw);
    chk({tag, ".if_id_flush"},   if_id_flush,   e_flush);
    chk({tag, ".id_ex_write"},   id_ex_write,   e_idw);
    chk({tag, ".id_ex_bubble"},  id_ex_bubble,  e_bub);
    chk({tag, ".ex_mem_bubble"}, ex_mem_bubble, e_exb);
    chk({tag, ".mdu_timeout"},   mdu_timeout,   m_sticky);
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, ".stall_cycles"},  stall_cycles,  64'(CNW'(m_stalls)));
    chk({tag, ".flush_count"},   flush_count,   64'(CNW'(m_flushes)));
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!e_pc)   m_stalls++;
      if (e_flush) m_flushes++;
      if (m_waiting) begin
        m_spent++;
        if (mdu_done) m_waiting = 0;
        else if (m_spent == TMO) begin m_waiting = 0; m_sticky = 1; end
      end else if (!ex_branch_taken && ex_mdu_start) begin
        m_waiting = 1; m_spent = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_ex_mem_read = 0; ex_branch_taken = 0; ex_mdu_start = 0; mdu_done = 0;
  endtask

  task automatic load_use_5();
    id_ex_mem_read = 1; id_ex_rd = 5; id_rs = 5; id_uses_rs = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    // reset held with hostile inputs: must stay pass-through
    load_use_5(); ex_branch_taken = 1;
    cycle("reset");
    idle();
    cycle("reset2");
    rst_n = 1;
    cycle("idle");

    load_use_5();              cycle("loaduse");
    idle();                    cycle("loaduse_after");
    load_use_5(); id_ex_rd = 0; id_rs = 0; cycle("rd_zero");
    load_use_5(); id_uses_rs = 0;          cycle("rs_unused");
    idle(); id_ex_mem_read = 1; id_ex_rd = 3; id_rt = 3; id_uses_rt = 1; cycle("loaduse_rt");
    load_use_5(); ex_branch_taken = 1;     cycle("branch_over_lu");
    ex_mdu_start = 1;                      cycle("branch_over_mdu");
    idle();                                cycle("post_branch");

    // MDU with done in the 4th wait cycle
    ex_mdu_start = 1; cycle("mdu_start");
    idle();
    for (int i = 1; i <= 4; i++) begin
      mdu_done = (i == 4);
      if (i == 2) begin load_use_5(); ex_branch_taken = 1; end
      cycle("mdu_wait");
      idle();
    end
    cycle("mdu_resume");
    chk("mdu_resume_pc", pc_write, 1'b1);
    mdu_done = 1; cycle("done_in_run");
    idle();

    // Watchdog
    ex_mdu_start = 1; load_use_5(); cycle("mdu_start_lu");
    idle();
    for (int i = 0; i < TMO; i++) cycle("watchdog_wait");
    cycle("watchdog_release");
    chk("watchdog_flag", mdu_timeout, 1'b1);
    for (int i = 0; i < 3; i++) cycle("sticky");

    // Reset on the 2nd wait cycle
    ex_mdu_start = 1; cycle("mdu_start_r");
    idle(); cycle("wait1");
    rst_n = 0; cycle("wait2_reset");
    rst_n = 1; cycle("after_reset");
    chk("after_reset_flag", mdu_timeout, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs           = RW'($urandom_range(0, 3));
      id_rt           = RW'($urandom_range(0, 3));
      id_ex_rd        = RW'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_ex_mem_read  = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mdu_start    = ($urandom_range(0, 7) == 0);
      mdu_done        = ($urandom_range(0, 11) == 0);
      rst_n           = ($urandom_range(0, 299) != 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
